// File: rtl/axis_pkt_arbiter_pkg.sv
// Shared definitions for the packet-path blocks: FSM encoding, default sizes
// and small index helpers.
package axis_pkt_arbiter_pkg;

    localparam int unsigned DEF_DW     = 128;
    localparam int unsigned DEF_NUM_IN = 4;

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_PASS = 1'b1;

    function automatic int unsigned one_bits(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    // Next index modulo n; valid for idx < n.
    function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/axis_pkt_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after last_idx+1,
// found by rotating a doubled request vector and priority-encoding it.
module rr_pick
    import axis_pkt_arbiter_pkg::*;
#(
    parameter int unsigned NUM_IN = DEF_NUM_IN,
    parameter int unsigned IW     = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IW-1:0]     last_idx,
    output logic              any_req,
    output logic [IW-1:0]     winner
);

    logic [2*NUM_IN-1:0] req_dbl;
    logic [NUM_IN-1:0]   req_rot;
    int unsigned         start;
    int unsigned         pos;

    always_comb begin
        req_dbl = {req, req};
        start   = wrap_next(32'(last_idx), NUM_IN);
        req_rot = req_dbl[start +: NUM_IN];
        any_req = |req;
        winner  = '0;
        pos     = 0;
        // Scan downward so the lowest rotated offset is the last one written.
        for (int unsigned i = NUM_IN; i > 0; i--) begin
            if (req_rot[i-1]) begin
                pos    = start + i - 1;
                if (pos >= NUM_IN) pos = pos - NUM_IN;
                winner = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin AXI-Stream merger; the grant only moves after
// a TLAST handshake so every output packet is contiguous.
module axis_pkt_arbiter
    import axis_pkt_arbiter_pkg::*;
#(
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned NUM_IN = DEF_NUM_IN,
    parameter int unsigned IW     = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN-1:0]        cfg_enable,
    input  logic [NUM_IN*DW-1:0]     axis_in_tdata,
    input  logic [NUM_IN*DW/8-1:0]   axis_in_tkeep,
    input  logic [NUM_IN-1:0]        axis_in_tlast,
    input  logic [NUM_IN-1:0]        axis_in_tvalid,
    output logic [NUM_IN-1:0]        axis_in_tready,
    output logic [DW-1:0]            axis_out_tdata,
    output logic [DW/8-1:0]          axis_out_tkeep,
    output logic                     axis_out_tlast,
    output logic                     axis_out_tvalid,
    output logic [IW-1:0]            axis_out_tid,
    input  logic                     axis_out_tready,
    output logic                     grant_active,
    output logic [31:0]              pkt_count
);

    localparam int unsigned KW = DW / 8;

    logic [0:0]        state;
    logic [IW-1:0]     grant_idx;
    logic [IW-1:0]     last_idx;
    logic [NUM_IN-1:0] req;
    logic              any_req;
    logic [IW-1:0]     winner;
    logic              last_hs;

    assign req = axis_in_tvalid & cfg_enable;

    rr_pick #(
        .NUM_IN (NUM_IN),
        .IW     (IW)
    ) u_rr_pick (
        .req      (req),
        .last_idx (last_idx),
        .any_req  (any_req),
        .winner   (winner)
    );

    // Pure combinational pass-through of the granted source; reset gates everything.
    always_comb begin
        axis_out_tdata  = '0;
        axis_out_tkeep  = '0;
        axis_out_tlast  = 1'b0;
        axis_out_tvalid = 1'b0;
        axis_in_tready  = '0;
        grant_active    = 1'b0;
        axis_out_tid    = reset ? '0 : grant_idx;
        if (!reset && state == ST_PASS) begin
            grant_active = 1'b1;
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                if (grant_idx == IW'(k)) begin
                    axis_out_tdata    = axis_in_tdata[k*DW +: DW];
                    axis_out_tkeep    = axis_in_tkeep[k*KW +: KW];
                    axis_out_tlast    = axis_in_tlast[k];
                    axis_out_tvalid   = axis_in_tvalid[k];
                    axis_in_tready[k] = axis_out_tready;
                end
            end
        end
    end

    assign last_hs = axis_out_tvalid & axis_out_tready & axis_out_tlast;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_ARB;
            grant_idx <= '0;
            last_idx  <= IW'(NUM_IN - 1);
            pkt_count <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (any_req) begin
                        grant_idx <= winner;
                        state     <= ST_PASS;
                    end
                end
                default: begin
                    if (last_hs) begin
                        last_idx  <= grant_idx;
                        pkt_count <= pkt_count + 32'd1;
                        state     <= ST_ARB;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench for axis_pkt_arbiter: arbitration table, directed
// corner-case sequences and randomized traffic against a packet-level model.
module tb_axis_pkt_arbiter;

    localparam int unsigned NI  = 4;
    localparam int unsigned DWB = 32;
    localparam int unsigned KW  = DWB / 8;
    localparam int unsigned IWB = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [NI-1:0]       cfg_enable;
    logic [NI*DWB-1:0]   in_tdata;
    logic [NI*KW-1:0]    in_tkeep;
    logic [NI-1:0]       in_tlast;
    logic [NI-1:0]       in_tvalid;
    logic [NI-1:0]       in_tready;
    logic [DWB-1:0]      out_tdata;
    logic [KW-1:0]       out_tkeep;
    logic                out_tlast;
    logic                out_tvalid;
    logic [IWB-1:0]      out_tid;
    logic                out_tready;
    logic                grant_active;
    logic [31:0]         pkt_count;

    axis_pkt_arbiter #(
        .DW     (DWB),
        .NUM_IN (NI),
        .IW     (IWB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cfg_enable      (cfg_enable),
        .axis_in_tdata   (in_tdata),
        .axis_in_tkeep   (in_tkeep),
        .axis_in_tlast   (in_tlast),
        .axis_in_tvalid  (in_tvalid),
        .axis_in_tready  (in_tready),
        .axis_out_tdata  (out_tdata),
        .axis_out_tkeep  (out_tkeep),
        .axis_out_tlast  (out_tlast),
        .axis_out_tvalid (out_tvalid),
        .axis_out_tid    (out_tid),
        .axis_out_tready (out_tready),
        .grant_active    (grant_active),
        .pkt_count       (pkt_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  en;
        int unsigned tid;
    } vec_t;

    typedef struct {
        int unsigned tid;
        logic [31:0] data;
        bit          last;
        int unsigned cyc;
    } beat_t;

    // Source drivers
    int unsigned len_q[NI][$];
    bit          endless[NI];
    int unsigned fixed_len = 0;
    int unsigned cur_len[NI];
    int unsigned beat[NI];
    int unsigned pkt_no[NI];
    bit          has_pkt[NI];
    bit          vld[NI];
    bit          hs[NI];
    int unsigned vprob = 100;
    int unsigned rdy_mode = 0;
    int unsigned rprob = 100;
    int unsigned cyc = 0;
    beat_t       log_q[$];

    // Reference model: which source holds the grant, and who won last
    bit          m_busy = 1'b0;
    int unsigned m_src  = 0;
    int unsigned m_last = NI - 1;
    logic [31:0] m_cnt  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input logic [31:0] d, input logic [3:0] kp,
                                         input logic l, input logic v, input logic [1:0] t,
                                         input logic [3:0] r, input logic g);
        return {19'b0, d, kp, l, v, t, r, g};
    endfunction

    function automatic logic [63:0] dut_outs();
        return pack(out_tdata, out_tkeep, out_tlast, out_tvalid, out_tid, in_tready, grant_active);
    endfunction

    task automatic drive_sources();
        logic [3:0] kfull;
        for (int k = 0; k < NI; k++) begin
            if (hs[k]) begin
                beat[k]++;
                if (beat[k] == cur_len[k]) begin
                    has_pkt[k] = 1'b0;
                    pkt_no[k]++;
                end
                vld[k] = 1'b0;
            end
            hs[k] = 1'b0;
            if (!has_pkt[k]) begin
                if (len_q[k].size() > 0) begin
                    cur_len[k] = len_q[k].pop_front();
                    has_pkt[k] = 1'b1;
                    beat[k]    = 0;
                end else if (endless[k]) begin
                    cur_len[k] = (fixed_len > 0) ? fixed_len : $urandom_range(1, 4);
                    has_pkt[k] = 1'b1;
                    beat[k]    = 0;
                end
            end
            if (has_pkt[k] && !vld[k]) vld[k] = ($urandom_range(0, 99) < vprob);
            if (!has_pkt[k]) vld[k] = 1'b0;
            kfull = 4'hF;
            in_tvalid[k]          = vld[k];
            in_tlast[k]           = has_pkt[k] && (beat[k] + 1 == cur_len[k]);
            in_tdata[k*DWB +: DWB] = {8'(k), 8'(pkt_no[k]), 8'(beat[k]), 8'(cur_len[k])};
            in_tkeep[k*KW +: KW]  = in_tlast[k] ? (kfull >> (cur_len[k] % 4)) : kfull;
        end
    endtask

    // One clock of traffic: drive, compare against the model, advance the model.
    task automatic cycle();
        logic [31:0] e_data;
        logic [3:0]  e_keep;
        logic        e_last, e_valid, e_ga;
        logic [1:0]  e_tid;
        logic [3:0]  e_rdy;
        int unsigned k;
        drive_sources();
        case (rdy_mode)
            0:       out_tready = 1'b1;
            1:       out_tready = ($urandom_range(0, 99) < rprob);
            default: out_tready = (cyc % 3 == 0);
        endcase
        #2;
        e_data = '0; e_keep = '0; e_last = 1'b0; e_valid = 1'b0; e_ga = 1'b0; e_rdy = '0;
        e_tid  = reset ? 2'd0 : 2'(m_src);
        if (!reset && m_busy) begin
            e_valid       = vld[m_src];
            e_data        = in_tdata[m_src*DWB +: DWB];
            e_keep        = in_tkeep[m_src*KW +: KW];
            e_last        = in_tlast[m_src];
            e_rdy[m_src]  = out_tready;
            e_ga          = 1'b1;
        end
        check("outs", dut_outs(), pack(e_data, e_keep, e_last, e_valid, e_tid, e_rdy, e_ga));
        check("pkt_count", {32'b0, pkt_count}, {32'b0, m_cnt});
        if (reset) begin
            m_busy = 1'b0;
            m_src  = 0;
            m_last = NI - 1;
            m_cnt  = '0;
        end else if (m_busy) begin
            if (vld[m_src] && out_tready) begin
                log_q.push_back('{m_src, e_data, e_last, cyc});
                hs[m_src] = 1'b1;
                if (e_last) begin
                    m_busy = 1'b0;
                    m_last = m_src;
                    m_cnt  = m_cnt + 1;
                end
            end
        end else begin
            for (int j = 1; j <= NI; j++) begin
                k = (m_last + j) % NI;
                if (!m_busy && vld[k] && cfg_enable[k]) begin
                    m_busy = 1'b1;
                    m_src  = k;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit idle;
        for (int n = 0; n < 200; n++) begin
            idle = !m_busy;
            for (int k = 0; k < NI; k++) if (has_pkt[k]) idle = 1'b0;
            if (idle) return;
            cycle();
        end
        check("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic set_endless(input logic [3:0] mask);
        for (int k = 0; k < NI; k++) endless[k] = mask[k];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[10];
        int unsigned prev_tid;
        int unsigned seq[3];
        int unsigned pk[$];
        int unsigned ne, n2, idx, nxt;
        int unsigned t0;
        bit          found;

        tbl[0] = '{4'b1111, 4'b1111, 0};
        tbl[1] = '{4'b1111, 4'b1011, 1};
        tbl[2] = '{4'b1111, 4'b1011, 3};
        tbl[3] = '{4'b0110, 4'b1111, 1};
        tbl[4] = '{4'b0010, 4'b1111, 1};
        tbl[5] = '{4'b1000, 4'b1000, 3};
        tbl[6] = '{4'b0101, 4'b1111, 0};
        tbl[7] = '{4'b0101, 4'b0111, 2};
        tbl[8] = '{4'b1001, 4'b1111, 3};
        tbl[9] = '{4'b1111, 4'b0001, 0};
        seq = '{0, 1, 3};

        reset = 1'b1; cfg_enable = '1; in_tdata = '0; in_tkeep = '0;
        in_tlast = '0; in_tvalid = '0; out_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset gates every combinational output even with traffic present
        in_tvalid = '1; in_tlast = '1; in_tkeep = '1;
        in_tdata  = {$urandom, $urandom, $urandom, $urandom};
        #2;
        check("reset_outs", dut_outs(), 64'd0);
        @(posedge clk); #1;
        in_tvalid = '0;
        reset = 1'b0;
        #1;
        check("post_reset_outs", dut_outs(), 64'd0);
        check("post_reset_cnt", {32'b0, pkt_count}, 64'd0);

        // Arbitration table: single-beat packets, one ARB and one PASS cycle each
        prev_tid = 0;
        foreach (tbl[i]) begin
            cfg_enable = tbl[i].en;
            in_tvalid  = tbl[i].valid;
            in_tlast   = '1;
            in_tkeep   = '1;
            for (int k = 0; k < NI; k++) in_tdata[k*DWB +: DWB] = $urandom;
            #1;
            check("tbl_arb", dut_outs(), pack('0, '0, 1'b0, 1'b0, 2'(prev_tid), '0, 1'b0));
            @(posedge clk); #2;
            check("tbl_pass", dut_outs(),
                  pack(in_tdata[tbl[i].tid*DWB +: DWB], 4'hF, 1'b1, 1'b1, 2'(tbl[i].tid),
                       4'(1 << tbl[i].tid), 1'b1));
            check("tbl_cnt", {32'b0, pkt_count}, 64'(i));
            @(posedge clk); #1;
            in_tvalid = '0;
            prev_tid  = tbl[i].tid;
        end
        m_busy = 1'b0; m_src = 0; m_last = 0; m_cnt = 32'd10;
        cfg_enable = '1;

        // Single source: 3-beat then 1-beat packet from source 2
        log_q.delete();
        t0 = cyc;
        len_q[2].push_back(3);
        len_q[2].push_back(1);
        repeat (8) cycle();
        check("ss_beats", 64'(log_q.size()), 64'd4);
        if (log_q.size() == 4) begin
            check("ss_tids", {log_q[0].tid[7:0], log_q[1].tid[7:0], log_q[2].tid[7:0], log_q[3].tid[7:0]},
                  64'h02020202);
            check("ss_last", {log_q[0].last, log_q[1].last, log_q[2].last, log_q[3].last}, 64'b0011);
            check("ss_latency", 64'(log_q[0].cyc - t0), 64'd1);
            check("ss_bubble", 64'(log_q[3].cyc - log_q[2].cyc), 64'd2);
        end
        check("ss_count", {32'b0, pkt_count}, 64'd12);

        // Fairness: sources 0,1,3 always valid with 2-beat packets
        log_q.delete();
        fixed_len = 2;
        set_endless(4'b1011);
        repeat (30) cycle();
        pk.delete();
        n2 = 0;
        foreach (log_q[i]) begin
            if (log_q[i].tid == 2) n2++;
            if (log_q[i].last) pk.push_back(log_q[i].tid);
        end
        ne = 0;
        foreach (pk[i]) if (pk[i] != seq[(i + 2) % 3]) ne++;
        check("fair_npkts", 64'(pk.size() >= 8), 64'd1);
        check("fair_order", 64'(ne), 64'd0);
        check("fair_no2", 64'(n2), 64'd0);
        set_endless(4'b0000);
        drain();

        // Backpressure: 4-beat packet from source 1 with tready 1,0,0,1,...
        log_q.delete();
        len_q[1].push_back(4);
        rdy_mode = 2;
        repeat (20) cycle();
        rdy_mode = 0;
        check("bp_beats", 64'(log_q.size()), 64'd4);
        ne = 0;
        foreach (log_q[i]) begin
            if (log_q[i].tid != 1 || log_q[i].data[15:8] != 8'(i) || log_q[i].last != (i == 3)) ne++;
        end
        check("bp_order", 64'(ne), 64'd0);

        // Enable masking with all sources valid
        log_q.delete();
        fixed_len = 3;
        cfg_enable = 4'b1011;
        set_endless(4'b1111);
        repeat (40) cycle();
        n2 = 0;
        foreach (log_q[i]) if (log_q[i].tid == 2) n2++;
        check("mask_no2", 64'(n2), 64'd0);
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            if (m_busy && m_src == 0) found = 1'b1;
            else cycle();
        end
        check("mask_wait_src0", 64'(found), 64'd1);
        cycle();
        cfg_enable = 4'b1010;
        idx = log_q.size();
        repeat (12) cycle();
        nxt = 99;
        found = 1'b0;
        for (int unsigned i = idx; i < log_q.size() && !found; i++) begin
            if (log_q[i].tid != 0) begin
                nxt = log_q[i].tid;
                found = 1'b1;
                check("mask_complete", 64'(i > idx && log_q[i-1].last), 64'd1);
            end
        end
        check("mask_next", 64'(nxt), 64'd1);
        set_endless(4'b0000);
        cfg_enable = '1;
        drain();

        // Reset on beat 2 of a 5-beat packet from source 3
        log_q.delete();
        len_q[3].push_back(5);
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            if (log_q.size() == 1) found = 1'b1;
            else cycle();
        end
        check("rst_wait_beat1", 64'(found), 64'd1);
        len_q[1].push_back(2);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        check("rst_cnt", {32'b0, pkt_count}, 64'd0);
        check("rst_ga", 64'(grant_active), 64'd0);
        log_q.delete();
        repeat (6) cycle();
        check("rst_next", 64'((log_q.size() > 0) ? log_q[0].tid : 99), 64'd1);
        drain();

        // Counter wrap
        force dut.pkt_count = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_count;
        m_cnt = 32'hFFFF_FFFF;
        len_q[0].push_back(1);
        repeat (4) cycle();
        check("wrap", {32'b0, pkt_count}, 64'd0);

        // Randomized traffic with backpressure, enable changes and a reset pulse
        fixed_len = 0;
        vprob = 60;
        rdy_mode = 1;
        rprob = 70;
        set_endless(4'b1111);
        for (int i = 0; i < 1500; i++) begin
            if (i % 25 == 0) cfg_enable = 4'($urandom);
            if (i == 700) reset = 1'b1;
            if (i == 702) reset = 1'b0;
            cycle();
        end
        cfg_enable = '1;
        set_endless(4'b0000);
        vprob = 100;
        rdy_mode = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
